// File: rtl/strobe_rate_meter.sv
// rtl/strobe_rate_meter.sv - multi-channel strobe edge-rate and edge-interval meter
//
// Purpose:
//   Counts rising edges of NCH single-bit aclk-domain strobes over a gate
//   window and latches the counts at every gate event. The gate is an
//   internal count of gate_len_i aclk cycles or the rising edge of an
//   external gate strobe. Independently, each channel measures the number
//   of aclk cycles between its last two rising edges and flags when two
//   consecutive intervals are equal.
//
// Ports:
//   aclk            clock
//   aresetn         asynchronous active-low reset
//   strobe_i        [NCH]            channel strobes
//   use_ext_gate_i  1: gate on ext_gate_i rising edge, 0: internal gate
//   ext_gate_i      external gate strobe
//   gate_len_i      [GATE_WIDTH]     internal gate length in cycles (min 2)
//   count_o         [NCH*CNT_WIDTH]  edges in last complete window, ch n at n*CNT_WIDTH
//   sat_o           [NCH]            latched window count saturated
//   count_valid_o   one-cycle pulse when count_o/sat_o update
//   interval_o      [NCH*CNT_WIDTH]  cycles between the last two edges per channel
//   stable_o        [NCH]            last two intervals were equal

module strobe_rate_meter #(
   parameter int NCH        = 4,
   parameter int CNT_WIDTH  = 32,
   parameter int GATE_WIDTH = 32
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NCH-1:0]           strobe_i,
   input  logic                     use_ext_gate_i,
   input  logic                     ext_gate_i,
   input  logic [GATE_WIDTH-1:0]    gate_len_i,
   output logic [NCH*CNT_WIDTH-1:0] count_o,
   output logic [NCH-1:0]           sat_o,
   output logic                     count_valid_o,
   output logic [NCH*CNT_WIDTH-1:0] interval_o,
   output logic [NCH-1:0]           stable_o
);

   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [GATE_WIDTH-1:0] GATE_ONE = GATE_WIDTH'(1);
   localparam logic [GATE_WIDTH-1:0] GATE_MIN = GATE_WIDTH'(2);

   // ------------------------------------------------------------------
   // Gate generation (shared by all channels)
   // ------------------------------------------------------------------
   logic                  ext_q;
   logic                  mode_q;
   logic                  first_q;     // first cycle after reset release
   logic [GATE_WIDTH-1:0] gate_cnt;
   logic [GATE_WIDTH-1:0] gate_len_q;  // length of the window in progress
   logic [GATE_WIDTH-1:0] len_in;
   logic [GATE_WIDTH-1:0] len_cur;
   logic                  ext_edge;
   logic                  mode_chg;
   logic                  int_wrap;
   logic                  gate_evt;

   always_comb begin
      len_in   = (gate_len_i < GATE_MIN) ? GATE_MIN : gate_len_i;
      // The window starting at reset release uses gate_len_i directly,
      // since no sampled length exists yet in that first cycle.
      len_cur  = first_q ? len_in : gate_len_q;
      ext_edge = ext_gate_i & ~ext_q;
      mode_chg = use_ext_gate_i ^ mode_q;
      int_wrap = ~use_ext_gate_i & (gate_cnt == (len_cur - GATE_ONE));
      // A mode change restarts the window, so no gate may close it.
      gate_evt = ~mode_chg & (use_ext_gate_i ? ext_edge : int_wrap);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ext_q         <= 1'b1;
         mode_q        <= 1'b0;
         first_q       <= 1'b1;
         gate_cnt      <= '0;
         gate_len_q    <= GATE_MIN;
         count_valid_o <= 1'b0;
      end else begin
         ext_q         <= ext_gate_i;
         mode_q        <= use_ext_gate_i;
         first_q       <= 1'b0;
         count_valid_o <= gate_evt;
         // Length is only resampled at a window boundary so a mid-window
         // change to gate_len_i affects the next window only.
         if (first_q || (int_wrap && !mode_chg)) begin
            gate_len_q <= len_in;
         end
         if (mode_chg || use_ext_gate_i || int_wrap) begin
            gate_cnt <= '0;
         end else begin
            gate_cnt <= gate_cnt + GATE_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-channel counting and interval measurement
   // ------------------------------------------------------------------
   for (genvar n = 0; n < NCH; n++) begin : g_ch
      logic                 strobe_q;
      logic                 rise;
      logic                 blocked;
      logic [CNT_WIDTH-1:0] acc;
      logic [CNT_WIDTH-1:0] acc_inc;
      logic                 sticky;
      logic [CNT_WIDTH-1:0] cnt_r;
      logic                 sat_r;
      logic [CNT_WIDTH-1:0] since;
      logic [CNT_WIDTH-1:0] since_inc;
      logic [CNT_WIDTH-1:0] ivl_r;
      logic                 stable_r;
      logic                 seen;
      logic                 ivalid;

      always_comb begin
         rise      = strobe_i[n] & ~strobe_q;
         blocked   = rise & (acc == CNT_MAX);
         acc_inc   = (rise && !blocked) ? (acc + CNT_ONE) : acc;
         since_inc = (since == CNT_MAX) ? since : (since + CNT_ONE);
      end

      // Window accumulator. acc_inc already includes this cycle's edge, so
      // an edge coincident with the gate is credited to the closing window.
      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            strobe_q <= 1'b1;   // a strobe held high through reset is not an edge
            acc      <= '0;
            sticky   <= 1'b0;
            cnt_r    <= '0;
            sat_r    <= 1'b0;
         end else begin
            strobe_q <= strobe_i[n];
            if (mode_chg) begin
               acc    <= '0;
               sticky <= 1'b0;
            end else if (gate_evt) begin
               cnt_r  <= acc_inc;
               sat_r  <= sticky | blocked;
               acc    <= '0;
               sticky <= 1'b0;
            end else begin
               acc    <= acc_inc;
               sticky <= sticky | blocked;
            end
         end
      end

      // Edge-to-edge interval. since counts cycles after the last edge, so
      // since+1 at the next edge is the edge spacing.
      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            since    <= '0;
            ivl_r    <= '0;
            stable_r <= 1'b0;
            seen     <= 1'b0;
            ivalid   <= 1'b0;
         end else if (rise) begin
            since <= '0;
            if (seen) begin
               ivl_r    <= since_inc;
               stable_r <= ivalid & (since_inc == ivl_r);
               ivalid   <= 1'b1;
            end else begin
               seen <= 1'b1;
            end
         end else begin
            since <= since_inc;
         end
      end

      assign count_o[n*CNT_WIDTH +: CNT_WIDTH]    = cnt_r;
      assign sat_o[n]                             = sat_r;
      assign interval_o[n*CNT_WIDTH +: CNT_WIDTH] = ivl_r;
      assign stable_o[n]                          = stable_r;
   end

endmodule
